// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong types and defaults for match control and scoring
// Contents:
//   match_state_t   round sequencer states
//   winner_t        rally winner latched between PLAY and POINT
//   SERVE_LEFT/SERVE_RIGHT  serve_dir encodings
//   DEF_WIN_POINTS/DEF_SERVE_TICKS  default match length and serve duration
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER,
    ST_PAUSED
  } match_state_t;

  typedef enum logic {
    WIN_P1,
    WIN_P2
  } winner_t;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  localparam int DEF_WIN_POINTS  = 7;
  localparam int DEF_SERVE_TICKS = 50;

endpackage

// File: rtl/match_ctrl_if.sv
// rtl/match_ctrl_if.sv - handshake bundle between the game top and the round sequencer
// Signals:
//   start, pause, tick, miss_l, miss_r   driven by the game side (master)
//   ball_en, ball_rst, serve_dir         ball physics control (slave)
//   p1vic, p2vic                         one-cycle point pulses (slave)
//   game_over, p1_score, p2_score        match status (slave)
interface match_ctrl_if;

  logic       start;
  logic       pause;
  logic       tick;
  logic       miss_l;
  logic       miss_r;
  logic       ball_en;
  logic       ball_rst;
  logic       serve_dir;
  logic       p1vic;
  logic       p2vic;
  logic       game_over;
  logic [2:0] p1_score;
  logic [2:0] p2_score;

  modport master (
    output start, pause, tick, miss_l, miss_r,
    input  ball_en, ball_rst, serve_dir, p1vic, p2vic, game_over, p1_score, p2_score
  );

  modport slave (
    input  start, pause, tick, miss_l, miss_r,
    output ball_en, ball_rst, serve_dir, p1vic, p2vic, game_over, p1_score, p2_score
  );

endinterface

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - rising-edge detector for an already synchronized level
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset, clears the history bit
//   i_level  synchronized input level
//   o_pulse  high for the one cycle in which i_level is high after being low
module rise_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  // The pulse is combinational on the current level so the sequencer can act
  // on the edge in the same cycle the button level rises.
  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - pong round sequencer: start, timed serve, play, point pulses, match end
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      match_ctrl_if.slave
//            in : start, pause, tick, miss_l, miss_r
//            out: ball_en, ball_rst, serve_dir, p1vic, p2vic, game_over, p1_score, p2_score
// Parameters:
//   WIN_POINTS   points that end the match (1..7)
//   SERVE_TICKS  tick pulses spent serving before the ball is released (1..255)
// Build option:
//   MATCH_PAUSE_EN  pause edges toggle SERVE/PLAY <-> PAUSED; when undefined the
//                   pause input is ignored and PAUSED is unreachable.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_POINTS  = DEF_WIN_POINTS,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS
) (
  input logic         i_clock,
  input logic         i_reset,
  match_ctrl_if.slave bus
);

  localparam logic [2:0] WIN_SCORE  = 3'(WIN_POINTS);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);

  match_state_t r_state;
  match_state_t w_next_state;
  match_state_t r_saved_state;
  match_state_t w_saved_next;
  winner_t      r_winner;
  winner_t      w_winner_next;
  logic [7:0]   r_serve_cnt;
  logic [7:0]   w_serve_cnt_next;
  logic [2:0]   r_p1_score;
  logic [2:0]   w_p1_next;
  logic [2:0]   r_p2_score;
  logic [2:0]   w_p2_next;
  logic         r_serve_dir;
  logic         w_serve_dir_next;
  logic         r_ball_en;
  logic         r_ball_rst;
  logic         r_p1vic;
  logic         r_p2vic;
  logic         r_game_over;
  logic         w_start_edge;
  logic         w_pause_edge;
  logic         w_pause_act;

  rise_edge u_start_edge (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_level (bus.start),
    .o_pulse (w_start_edge)
  );

  rise_edge u_pause_edge (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_level (bus.pause),
    .o_pulse (w_pause_edge)
  );

`ifdef MATCH_PAUSE_EN
  assign w_pause_act = w_pause_edge;
`else
  logic w_unused_pause;
  assign w_pause_act    = 1'b0;
  assign w_unused_pause = w_pause_edge;
`endif

  always_comb begin
    w_next_state     = r_state;
    w_saved_next     = r_saved_state;
    w_winner_next    = r_winner;
    w_serve_cnt_next = r_serve_cnt;
    w_p1_next        = r_p1_score;
    w_p2_next        = r_p2_score;
    w_serve_dir_next = r_serve_dir;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_p1_next        = '0;
          w_p2_next        = '0;
          w_serve_dir_next = SERVE_LEFT;
          w_next_state     = ST_SERVE;
        end
      end

      ST_SERVE: begin
        // A pause edge takes priority over a tick in the same cycle, so the
        // tick is not counted and the count is saved exactly as it stood.
        if (w_pause_act) begin
          w_saved_next = ST_SERVE;
          w_next_state = ST_PAUSED;
        end else if (bus.tick) begin
          if (r_serve_cnt == SERVE_LAST) begin
            w_serve_cnt_next = '0;
            w_next_state     = ST_PLAY;
          end else begin
            w_serve_cnt_next = r_serve_cnt + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        if (w_pause_act) begin
          w_saved_next = ST_PLAY;
          w_next_state = ST_PAUSED;
        end else if (bus.miss_l && bus.miss_r) begin
          // Ball lost on both sides at once: replay the rally, nobody scores.
          w_next_state = ST_SERVE;
        end else if (bus.miss_r) begin
          w_winner_next = WIN_P1;
          w_next_state  = ST_POINT;
        end else if (bus.miss_l) begin
          w_winner_next = WIN_P2;
          w_next_state  = ST_POINT;
        end
      end

      ST_POINT: begin
        if (r_winner == WIN_P1) begin
          if (r_p1_score != WIN_SCORE) begin
            w_p1_next = r_p1_score + 3'd1;
          end
          w_serve_dir_next = SERVE_RIGHT;
        end else begin
          if (r_p2_score != WIN_SCORE) begin
            w_p2_next = r_p2_score + 3'd1;
          end
          w_serve_dir_next = SERVE_LEFT;
        end
        if ((w_p1_next == WIN_SCORE) || (w_p2_next == WIN_SCORE)) begin
          w_next_state = ST_OVER;
        end else begin
          w_next_state = ST_SERVE;
        end
      end

      ST_OVER: begin
        if (w_start_edge) begin
          w_p1_next    = '0;
          w_p2_next    = '0;
          w_next_state = ST_SERVE;
        end
      end

      ST_PAUSED: begin
        // Start and misses are deliberately ignored here; only the next pause
        // edge leaves, and the serve counter was never touched.
        if (w_pause_act) begin
          w_next_state = r_saved_state;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are decoded from the next state and registered, so each output
  // reflects the state the sequencer is in during that cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_saved_state <= ST_IDLE;
      r_winner      <= WIN_P1;
      r_serve_cnt   <= '0;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
      r_serve_dir   <= SERVE_LEFT;
      r_ball_en     <= 1'b0;
      r_ball_rst    <= 1'b1;
      r_p1vic       <= 1'b0;
      r_p2vic       <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_saved_state <= w_saved_next;
      r_winner      <= w_winner_next;
      r_serve_cnt   <= w_serve_cnt_next;
      r_p1_score    <= w_p1_next;
      r_p2_score    <= w_p2_next;
      r_serve_dir   <= w_serve_dir_next;
      r_ball_en     <= (w_next_state == ST_PLAY);
      r_ball_rst    <= (w_next_state == ST_IDLE) || (w_next_state == ST_SERVE) ||
                       (w_next_state == ST_OVER) ||
                       ((w_next_state == ST_PAUSED) && (w_saved_next == ST_SERVE));
      r_p1vic       <= (w_next_state == ST_POINT) && (w_winner_next == WIN_P1);
      r_p2vic       <= (w_next_state == ST_POINT) && (w_winner_next == WIN_P2);
      r_game_over   <= (w_next_state == ST_OVER);
    end
  end

  assign bus.ball_en   = r_ball_en;
  assign bus.ball_rst  = r_ball_rst;
  assign bus.serve_dir = r_serve_dir;
  assign bus.p1vic     = r_p1vic;
  assign bus.p2vic     = r_p2vic;
  assign bus.game_over = r_game_over;
  assign bus.p1_score  = r_p1_score;
  assign bus.p2_score  = r_p2_score;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - self-checking bench for match_ctrl with a behavioural round model
module tb_match_ctrl;

  localparam int WP = 7;
  localparam int ST = 3;
`ifdef MATCH_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int M_IDLE   = 0;
  localparam int M_SERVE  = 1;
  localparam int M_PLAY   = 2;
  localparam int M_POINT  = 3;
  localparam int M_OVER   = 4;
  localparam int M_PAUSED = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_p1_pulses = 0;
  int   n_p2_pulses = 0;

  match_ctrl_if bus ();

  match_ctrl #(
    .WIN_POINTS  (WP),
    .SERVE_TICKS (ST)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the match looks like from the outside.
  int m_mode;
  int m_saved;
  int m_ticks;
  int m_p1;
  int m_p2;
  int m_dir;
  int m_win;
  bit m_start_q;
  bit m_pause_q;
  bit s_edge;
  bit p_edge;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode    = M_IDLE;
      m_saved   = M_IDLE;
      m_ticks   = 0;
      m_p1      = 0;
      m_p2      = 0;
      m_dir     = 0;
      m_win     = 0;
      m_start_q = 1'b0;
      m_pause_q = 1'b0;
    end else begin
      s_edge    = bus.start && !m_start_q;
      p_edge    = PAUSE_EN && bus.pause && !m_pause_q;
      m_start_q = bus.start;
      m_pause_q = bus.pause;
      case (m_mode)
        M_IDLE: if (s_edge) begin
          m_p1 = 0; m_p2 = 0; m_dir = 0; m_mode = M_SERVE;
        end
        M_SERVE: begin
          if (p_edge) begin
            m_saved = M_SERVE; m_mode = M_PAUSED;
          end else if (bus.tick) begin
            m_ticks++;
            if (m_ticks == ST) begin m_ticks = 0; m_mode = M_PLAY; end
          end
        end
        M_PLAY: begin
          if (p_edge) begin
            m_saved = M_PLAY; m_mode = M_PAUSED;
          end else if (bus.miss_l && bus.miss_r) m_mode = M_SERVE;
          else if (bus.miss_r) begin m_win = 1; m_mode = M_POINT; end
          else if (bus.miss_l) begin m_win = 2; m_mode = M_POINT; end
        end
        M_POINT: begin
          if (m_win == 1) begin
            if (m_p1 < WP) m_p1++;
            m_dir = 1;
          end else begin
            if (m_p2 < WP) m_p2++;
            m_dir = 0;
          end
          m_mode = (m_p1 == WP || m_p2 == WP) ? M_OVER : M_SERVE;
        end
        M_OVER: if (s_edge) begin
          m_p1 = 0; m_p2 = 0; m_mode = M_SERVE;
        end
        M_PAUSED: if (p_edge) m_mode = m_saved;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  logic [11:0] exp_v;
  logic [11:0] act_v;

  always @(negedge clk) begin
    if (bus.p1vic === 1'b1) n_p1_pulses++;
    if (bus.p2vic === 1'b1) n_p2_pulses++;
    if (cmp_en) begin
      exp_v[11]  = (m_mode == M_PLAY);
      exp_v[10]  = (m_mode inside {M_IDLE, M_SERVE, M_OVER}) ||
                   (m_mode == M_PAUSED && m_saved == M_SERVE);
      exp_v[9]   = m_dir[0];
      exp_v[8]   = (m_mode == M_POINT) && (m_win == 1);
      exp_v[7]   = (m_mode == M_POINT) && (m_win == 2);
      exp_v[6]   = (m_mode == M_OVER);
      exp_v[5:3] = m_p1[2:0];
      exp_v[2:0] = m_p2[2:0];
      act_v = {bus.ball_en, bus.ball_rst, bus.serve_dir, bus.p1vic, bus.p2vic,
               bus.game_over, bus.p1_score, bus.p2_score};
      check("cycle_outputs", act_v, exp_v);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic to_play();
    int i = 0;
    while (bus.ball_en !== 1'b1 && i < 40) begin
      bus.tick = 1'b1;
      cyc();
      i++;
    end
    bus.tick = 1'b0;
    check("reach_play", bus.ball_en, 1);
  endtask

  int base;

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    bus.miss_l = 1'b0; bus.miss_r = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    cmp_en = 1'b1;
    check("rst_ball_rst", bus.ball_rst, 1);
    check("rst_ball_en", bus.ball_en, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_vic", {bus.p1vic, bus.p2vic}, 0);
    check("rst_scores", {bus.p1_score, bus.p2_score}, 0);
    #2 rst = 1'b0;
    cyc();

    // Start and a serve with a tick every 4 cycles.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    check("start_serve_rst", bus.ball_rst, 1);
    check("start_scores", {bus.p1_score, bus.p2_score}, 0);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) cyc();
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      if (k == 2) check("serve_tick2_no_en", bus.ball_en, 0);
    end
    check("serve_tick3_en", bus.ball_en, 1);

    // Single-cycle miss_r: one p1vic, then score/serve_dir update.
    bus.miss_r = 1'b1; cyc(); bus.miss_r = 1'b0;
    check("point_p1vic", bus.p1vic, 1);
    check("point_ball_en_low", bus.ball_en, 0);
    cyc();
    check("after_point_p1vic", bus.p1vic, 0);
    check("p1_score_1", bus.p1_score, 1);
    check("serve_dir_1", bus.serve_dir, 1);
    check("serve_after_point", bus.ball_rst, 1);

    // Held miss_r still yields a single pulse.
    to_play();
    base = n_p1_pulses;
    bus.miss_r = 1'b1; repeat (5) cyc(); bus.miss_r = 1'b0; cyc();
    check("held_miss_one_pulse", n_p1_pulses - base, 1);
    check("p1_score_2", bus.p1_score, 2);

    // Let: both misses together.
    to_play();
    base = n_p1_pulses + n_p2_pulses;
    bus.miss_l = 1'b1; bus.miss_r = 1'b1; cyc();
    bus.miss_l = 1'b0; bus.miss_r = 1'b0; cyc();
    check("let_no_pulse", n_p1_pulses + n_p2_pulses - base, 0);
    check("let_serve", {bus.ball_en, bus.ball_rst}, 2'b01);
    check("let_scores", {bus.p1_score, bus.p2_score}, {3'd2, 3'd0});

    // P2 takes seven straight points.
    base = n_p2_pulses;
    for (int k = 0; k < 7; k++) begin
      to_play();
      bus.miss_l = 1'b1; cyc(); bus.miss_l = 1'b0; cyc();
    end
    check("p2_seven_pulses", n_p2_pulses - base, 7);
    check("over_game_over", bus.game_over, 1);
    check("over_scores", {bus.p1_score, bus.p2_score}, {3'd2, 3'd7});
    base = n_p1_pulses + n_p2_pulses;
    for (int k = 0; k < 10; k++) begin
      bus.tick = 1'b1; bus.miss_l = 1'($urandom_range(0, 1)); bus.miss_r = 1'b1;
      cyc();
    end
    bus.tick = 1'b0; bus.miss_l = 1'b0; bus.miss_r = 1'b0; cyc();
    check("over_no_pulse", n_p1_pulses + n_p2_pulses - base, 0);
    check("over_holds", bus.game_over, 1);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    check("restart_scores", {bus.p1_score, bus.p2_score}, 0);
    check("restart_game_over", bus.game_over, 0);
    check("restart_serve", bus.ball_rst, 1);

    // Asynchronous reset mid-PLAY, mid-SERVE and with a pulse in flight.
    to_play();
    bus.miss_r = 1'b1; cyc(); bus.miss_r = 1'b0; cyc();
    to_play();
    rst = 1'b1; #1;
    check("rst_play_ball_rst", bus.ball_rst, 1);
    check("rst_play_ball_en", bus.ball_en, 0);
    check("rst_play_p1_score", bus.p1_score, 0);
    cyc(); rst = 1'b0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    rst = 1'b1; #1;
    check("rst_serve_outs", {bus.ball_en, bus.ball_rst, bus.game_over}, 3'b010);
    cyc(); rst = 1'b0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    to_play();
    bus.miss_r = 1'b1; cyc(); bus.miss_r = 1'b0;
    check("pulse_before_rst", bus.p1vic, 1);
    rst = 1'b1; #1;
    check("pulse_lost", bus.p1vic, 0);
    cyc(); rst = 1'b0; cyc();
    check("idle_after_rst_score", bus.p1_score, 0);

    // Pause in SERVE at count 2.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    bus.tick = 1'b1; repeat (2) cyc(); bus.tick = 1'b0;
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    bus.tick = 1'b1; repeat (10) cyc(); bus.tick = 1'b0;
    check("pause_hold_en", bus.ball_en, PAUSE_EN ? 0 : 1);
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    check("unpause_en", bus.ball_en, PAUSE_EN ? 0 : 1);
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    check("resume_count", bus.ball_en, 1);

    // Randomized rallies with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      bus.start  = ($urandom_range(0, 15) == 0);
      bus.pause  = ($urandom_range(0, 31) == 0);
      bus.tick   = ($urandom_range(0, 2) == 0);
      bus.miss_l = ($urandom_range(0, 9) == 0);
      bus.miss_r = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 599) == 0);
      cyc();
    end
    bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    bus.miss_l = 1'b0; bus.miss_r = 1'b0; rst = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
